// File: rtl/yolo_pkg.sv
// Shared constants, lane types and helpers for the requantisation datapath.
// Widths are sized so that no intermediate value can overflow.
package yolo_pkg;

    localparam int LANES     = 8;
    localparam int ACC_W     = 32;
    localparam int DATA_W    = 8;
    localparam int SCALE_W   = 16;
    localparam int BIAS_W    = 32;
    localparam int CFG_W     = SCALE_W + BIAS_W;
    localparam int LEAKY_MUL = 13;
    localparam int LEAKY_SH  = 7;

    localparam int SUM_W  = ACC_W + 1;
    localparam int PROD_W = SUM_W + SCALE_W + 1;
    localparam int RND_W  = PROD_W + 5;

    localparam logic signed [RND_W-1:0] LEAKY_MUL_S = RND_W'(LEAKY_MUL);
    localparam logic signed [RND_W-1:0] Q_MAX       = RND_W'(127);
    localparam logic signed [RND_W-1:0] Q_MIN       = RND_W'(-128);

    typedef logic signed [ACC_W-1:0]  lane_acc_t;
    typedef logic signed [DATA_W-1:0] lane_q_t;

    // Field order matches the packed cfg_data word: {scale, bias}.
    typedef struct packed {
        logic [SCALE_W-1:0] scale;
        logic [BIAS_W-1:0]  bias;
    } coef_t;

    function automatic lane_q_t sat_q(input logic signed [RND_W-1:0] v);
        if (v > Q_MAX) begin
            return 8'h7F;
        end
        if (v < Q_MIN) begin
            return 8'h80;
        end
        return v[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/quant_lane.sv
// One lane of the requantiser: bias add and scale multiply (S2), then
// leaky ReLU, round-half-up shift and int8 saturation (S3).
module quant_lane
    import yolo_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      v1_i,
    input  logic      v2_i,
    input  lane_acc_t acc_i,
    input  coef_t     coef_i,
    input  logic [4:0] shift_i,
    input  logic      leaky_en_i,
    output lane_q_t   q_o
);

    logic signed [SUM_W-1:0]  sum;
    logic signed [PROD_W-1:0] prod_d;
    logic signed [PROD_W-1:0] prod_q;
    logic signed [RND_W-1:0]  p_ext;
    logic signed [RND_W-1:0]  leak;
    logic signed [RND_W-1:0]  pl;
    logic signed [RND_W-1:0]  rnd;
    logic signed [RND_W-1:0]  r;
    lane_q_t                  q_d;
    lane_q_t                  q_q;

    // Scale is unsigned, so it is zero-extended before the signed multiply.
    always_comb begin
        sum    = $signed({acc_i[ACC_W-1], acc_i}) + $signed({coef_i.bias[BIAS_W-1], coef_i.bias});
        prod_d = $signed({{(PROD_W-SUM_W){sum[SUM_W-1]}}, sum})
               * $signed({{(PROD_W-SCALE_W){1'b0}}, coef_i.scale});
    end

    always_comb begin
        p_ext = $signed({{(RND_W-PROD_W){prod_q[PROD_W-1]}}, prod_q});
        leak  = (p_ext * LEAKY_MUL_S) >>> LEAKY_SH;
        pl    = (leaky_en_i && prod_q[PROD_W-1]) ? leak : p_ext;
        rnd   = '0;
        if (shift_i != 5'd0) begin
            rnd = RND_W'(1) << (shift_i - 5'd1);
        end
        r   = (pl + rnd) >>> shift_i;
        q_d = sat_q(r);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
            q_q    <= '0;
        end else begin
            if (v1_i) begin
                prod_q <= prod_d;
            end
            if (v2_i) begin
                q_q <= q_d;
            end
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/quant_leaky.sv
// Requantisation stage: per-channel bias/scale, layer shift, optional leaky
// ReLU and int8 saturation over 8 lanes; 3-cycle latency, full throughput.
module quant_leaky
    import yolo_pkg::*;
#(
    parameter int MAX_CH = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [15:0]               channels,
    input  logic [4:0]                shift,
    input  logic                      leaky_en,
    input  logic                      cfg_we,
    input  logic [$clog2(MAX_CH)-1:0] cfg_addr,
    input  logic [CFG_W-1:0]          cfg_data,
    input  logic [LANES*ACC_W-1:0]    acc_in,
    input  logic                      valid_in,
    output logic [LANES*DATA_W-1:0]   data_out,
    output logic                      valid_out
);

    localparam int DEPTH = MAX_CH / LANES;
    localparam int GW    = $clog2(DEPTH);
    localparam int AW    = $clog2(MAX_CH);

    logic [GW-1:0] grp_q;
    logic [GW-1:0] grp_d;
    logic [GW-1:0] grp_rd;
    logic          grp_last;
    logic          v1_q;
    logic          v2_q;

    // A start pulse coinciding with a beat makes that beat group 0.
    assign grp_rd   = start ? '0 : grp_q;
    assign grp_last = (16'({grp_rd, 3'b000}) + 16'd8) == channels;

    always_comb begin
        grp_d = grp_rd;
        if (valid_in) begin
            grp_d = grp_last ? '0 : grp_rd + GW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grp_q     <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            grp_q     <= grp_d;
            v1_q      <= valid_in;
            v2_q      <= v1_q;
            valid_out <= v2_q;
        end
    end

    generate
        for (genvar b = 0; b < LANES; b++) begin : g_lane
            coef_t     mem [DEPTH];
            coef_t     coef_q;
            lane_acc_t acc_q;
            lane_q_t   q;

            // Read and write share the edge, so a same-cycle write is not seen by the read.
            always_ff @(posedge clk) begin
                if (cfg_we && cfg_addr[2:0] == 3'(b)) begin
                    mem[cfg_addr[AW-1:3]] <= coef_t'(cfg_data);
                end
                if (valid_in) begin
                    coef_q <= mem[grp_rd];
                    acc_q  <= acc_in[ACC_W*b +: ACC_W];
                end
            end

            quant_lane u_lane (
                .clk        (clk),
                .rst        (rst),
                .v1_i       (v1_q),
                .v2_i       (v2_q),
                .acc_i      (acc_q),
                .coef_i     (coef_q),
                .shift_i    (shift),
                .leaky_en_i (leaky_en),
                .q_o        (q)
            );

            assign data_out[DATA_W*b +: DATA_W] = q;
        end
    endgenerate

endmodule

// File: tb/tb_quant_leaky.sv
// Bench for quant_leaky: directed cases plus randomized layers checked
// against an arithmetic reference model of the requantiser.
module tb_quant_leaky;
    import yolo_pkg::*;

    localparam int MAX_CH = 1024;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [15:0]  channels;
    logic [4:0]   shift;
    logic         leaky_en;
    logic         cfg_we;
    logic [9:0]   cfg_addr;
    logic [47:0]  cfg_data;
    logic [255:0] acc_in;
    logic         valid_in;
    logic [63:0]  data_out;
    logic         valid_out;

    always #5 clk = ~clk;

    quant_leaky #(.MAX_CH(MAX_CH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .channels  (channels),
        .shift     (shift),
        .leaky_en  (leaky_en),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .acc_in    (acc_in),
        .valid_in  (valid_in),
        .data_out  (data_out),
        .valid_out (valid_out)
    );

    int n_pass   = 0;
    int n_checks = 0;

    logic [47:0] coef_m [MAX_CH];
    int          m_grp = 0;
    logic        e1_v = 1'b0, e2_v = 1'b0, eo_v = 1'b0;
    logic [63:0] e1_d = '0, e2_d = '0, eo_d = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [7:0] ref_lane(input int acc, input logic [47:0] cf,
                                            input int sh, input bit lk);
        longint s, p, r;
        s = longint'(acc) + longint'($signed(cf[31:0]));
        p = s * longint'(cf[47:32]);
        if (lk && p < 0) p = (p * 13) >>> 7;
        if (sh > 0) p = p + (longint'(1) << (sh - 1));
        r = p >>> sh;
        if (r > 127)  return 8'h7F;
        if (r < -128) return 8'h80;
        return r[7:0];
    endfunction

    function automatic logic [63:0] ref_beat(input logic [255:0] acc, input int g,
                                             input int sh, input bit lk);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) begin
            v[8*i +: 8] = ref_lane($signed(acc[32*i +: 32]), coef_m[8*g + i], sh, lk);
        end
        return v;
    endfunction

    function automatic logic [63:0] bias_vec(input int g);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) begin
            v[8*i +: 8] = 8'((g*8 + i)*5 - 40);
        end
        return v;
    endfunction

    // Model the edge with the inputs currently applied, then clock and check.
    task automatic tick();
        logic        nv;
        logic [63:0] nd;
        int          ge;
        nv = 1'b0;
        nd = '0;
        ge = start ? 0 : m_grp;
        if (!rst && valid_in) begin
            nv = 1'b1;
            nd = ref_beat(acc_in, ge, int'(shift), leaky_en);
        end
        if (rst) begin
            eo_v = 1'b0; eo_d = '0; e2_v = 1'b0; e1_v = 1'b0; m_grp = 0;
        end else begin
            eo_v = e2_v;
            if (e2_v) eo_d = e2_d;
            e2_v = e1_v; e2_d = e1_d;
            e1_v = nv;   e1_d = nd;
            if (valid_in) m_grp = (ge + 1 == int'(channels) / 8) ? 0 : ge + 1;
            else          m_grp = ge;
        end
        if (cfg_we) coef_m[cfg_addr] = cfg_data;
        @(posedge clk);
        @(negedge clk);
        check("valid_out", {63'b0, valid_out}, {63'b0, eo_v});
        if (eo_v) check("data_out", data_out, eo_d);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wr(input int ch, input int sc, input int b);
        cfg_we   = 1'b1;
        cfg_addr = 10'(ch);
        cfg_data = {sc[15:0], b};
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic set_acc(input int v);
        for (int i = 0; i < 8; i++) acc_in[32*i +: 32] = v;
    endtask

    task automatic beat_const(input int v);
        set_acc(v);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; channels = 16'd8; shift = 5'd0; leaky_en = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; acc_in = '0; valid_in = 1'b0;
        for (int i = 0; i < MAX_CH; i++) coef_m[i] = '0;
        idle(3);
        check("rst_data", data_out, 64'h0);
        rst = 1'b0;

        // Positive rounding
        for (int c = 0; c < 8; c++) wr(c, 1, 24);
        shift = 5'd4;
        pulse_start();
        beat_const(1000);
        idle(2);
        check("rnd_pos", data_out, {8{8'h40}});

        // Leaky, then same stimulus without leaky
        for (int c = 0; c < 8; c++) wr(c, 1, -24);
        shift = 5'd0; leaky_en = 1'b1;
        beat_const(-1000);
        idle(2);
        check("leaky", data_out, {8{8'h98}});
        leaky_en = 1'b0;
        beat_const(-1000);
        idle(2);
        check("sat_neg", data_out, {8{8'h80}});

        // Positive saturation and negative rounding
        beat_const(100000);
        idle(2);
        check("sat_pos", data_out, {8{8'h7F}});
        for (int c = 0; c < 8; c++) wr(c, 1, 0);
        shift = 5'd4;
        beat_const(-24);
        idle(2);
        check("rnd_neg", data_out, {8{8'hFF}});

        // Group wrap and start-with-beat
        channels = 16'd16; shift = 5'd0;
        for (int c = 0; c < 16; c++) wr(c, 1, c*5 - 40);
        pulse_start();
        set_acc(0);
        valid_in = 1'b1;
        tick();
        tick();
        tick();
        check("grp_b1", data_out, bias_vec(0));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("grp_b2", data_out, bias_vec(1));
        tick();
        check("grp_b3", data_out, bias_vec(0));
        valid_in = 1'b0;
        tick();
        check("start_b4", data_out, bias_vec(0));
        tick();
        check("start_b5", data_out, bias_vec(1));

        // Write to channel 0 colliding with a group-0 beat
        pulse_start();
        valid_in = 1'b1;
        cfg_we = 1'b1; cfg_addr = 10'd0; cfg_data = {16'd1, 32'd77};
        tick();
        cfg_we = 1'b0;
        tick();
        tick();
        check("coll_old", {56'b0, data_out[7:0]}, {56'b0, 8'hD8});
        valid_in = 1'b0;
        tick();
        tick();
        check("coll_new", {56'b0, data_out[7:0]}, {56'b0, 8'h4D});

        // Reset in the middle of a stream
        pulse_start();
        valid_in = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            for (int i = 0; i < 8; i++) acc_in[32*i +: 32] = int'($urandom_range(0, 200)) - 100;
            if (k == 5) rst = 1'b1;
            tick();
            if (k >= 5) check("rst_vout", {63'b0, valid_out}, 64'h0);
        end
        valid_in = 1'b0;
        rst = 1'b0;
        pulse_start();
        set_acc(7);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        check("lat_1", {63'b0, valid_out}, 64'h0);
        tick();
        check("lat_2", {63'b0, valid_out}, 64'h0);
        tick();
        check("lat_3", {63'b0, valid_out}, 64'h1);

        // Randomized layers
        for (int layer = 0; layer < 8; layer++) begin
            idle(4);
            channels = 16'(8 * $urandom_range(1, 8));
            shift    = 5'($urandom_range(0, 31));
            leaky_en = 1'($urandom_range(0, 1));
            for (int c = 0; c < int'(channels); c++) begin
                wr(c, $urandom_range(0, 1) != 0 ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 64)),
                   $urandom_range(0, 1) != 0 ? int'($urandom) : int'($urandom_range(0, 400)) - 200);
            end
            pulse_start();
            for (int cyc = 0; cyc < 150; cyc++) begin
                valid_in = ($urandom_range(0, 3) != 0);
                start    = ($urandom_range(0, 19) == 0);
                cfg_we   = ($urandom_range(0, 9) == 0);
                cfg_addr = 10'($urandom_range(0, int'(channels) - 1));
                cfg_data = {16'($urandom_range(0, 300)), 32'($urandom)};
                for (int i = 0; i < 8; i++) begin
                    acc_in[32*i +: 32] = ($urandom_range(0, 1) != 0) ? $urandom
                                       : 32'(int'($urandom_range(0, 4000)) - 2000);
                end
                tick();
            end
            valid_in = 1'b0; start = 1'b0; cfg_we = 1'b0;
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
